// File: rtl/flash_pattern_gen_pkg.sv
// Shared types and constants for the lag-test flash pattern generator.
package flash_pattern_gen_pkg;

  localparam int unsigned COORD_W     = 12;
  localparam int unsigned COLOR_W_DEF = 24;
  localparam int unsigned COUNT_W     = 16;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'd0,
    MODE_RR   = 2'd1,
    MODE_INV  = 2'd2,
    MODE_RSVD = 2'd3
  } flash_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } flash_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
  } field_rect_t;

  // Half-open interval membership; hi <= lo yields an empty span.
  function automatic logic in_span(input logic [COORD_W-1:0] v,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/flash_pattern_gen_hit.sv
// Combinational per-field rectangle hit test for the current pixel.
module flash_field_hit
  import flash_pattern_gen_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 3
) (
  input  logic [COORD_W-1:0]               xpos,
  input  logic [COORD_W-1:0]               ypos,
  input  field_rect_t [NUM_FIELDS-1:0]     rects,
  output logic [NUM_FIELDS-1:0]            hit_c
);

  always_comb begin
    hit_c = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      hit_c[k] = in_span(xpos, rects[k].x0, rects[k].x1) &&
                 in_span(ypos, rects[k].y0, rects[k].y1);
    end
  end

endmodule

// File: rtl/flash_pattern_gen.sv
// Periodic flash-field generator with onset trigger, jittered period and a
// 1-bit overlay layer; one pixel per clock with a single register stage.
module flash_pattern_gen
  import flash_pattern_gen_pkg::*;
#(
  parameter int unsigned NUM_FIELDS    = 3,
  parameter int unsigned PERIOD_FRAMES = 32,
  parameter int unsigned ON_FRAMES     = 4,
  parameter int unsigned JITTER_STEPS  = 8,
  parameter int unsigned COLOR_W       = COLOR_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            xpos,
  input  logic [COORD_W-1:0]            ypos,
  input  logic [COORD_W*NUM_FIELDS-1:0] field_x0,
  input  logic [COORD_W*NUM_FIELDS-1:0] field_x1,
  input  logic [COORD_W*NUM_FIELDS-1:0] field_y0,
  input  logic [COORD_W*NUM_FIELDS-1:0] field_y1,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic [COLOR_W-1:0]            fg_color,
  input  logic [COLOR_W-1:0]            bg_color,
  input  logic                          overlay_en,
  input  logic                          overlay_pix,
  output logic                          starttrigger,
  output logic                          flash_active,
  output logic [COLOR_W-1:0]            data,
  output logic                          data_valid,
  output logic [COUNT_W-1:0]            flash_count
);

  localparam int unsigned CNT_W = $clog2(PERIOD_FRAMES + JITTER_STEPS);
  localparam int unsigned JIT_W = (JITTER_STEPS > 1) ? $clog2(JITTER_STEPS) : 1;
  localparam int unsigned RR_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  flash_state_e          state;
  flash_mode_e           mode_q;
  logic [CNT_W-1:0]      frame_cnt;
  logic [JIT_W-1:0]      jitter;
  logic [RR_W-1:0]       rr_idx;

  field_rect_t [NUM_FIELDS-1:0] rects;
  logic [NUM_FIELDS-1:0]        field_hit_c;
  logic                         any_hit_c;
  logic                         rr_hit_c;
  logic                         lit_hit_c;
  logic [CNT_W-1:0]             period_end_c;
  logic [COLOR_W-1:0]           pix_c;

  // Unpack flat field-bound buses into rectangle records.
  always_comb begin
    rects = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      rects[k].x0 = field_x0[COORD_W*k +: COORD_W];
      rects[k].x1 = field_x1[COORD_W*k +: COORD_W];
      rects[k].y0 = field_y0[COORD_W*k +: COORD_W];
      rects[k].y1 = field_y1[COORD_W*k +: COORD_W];
    end
  end

  flash_field_hit #(
    .NUM_FIELDS (NUM_FIELDS)
  ) u_hit (
    .xpos  (xpos),
    .ypos  (ypos),
    .rects (rects),
    .hit_c (field_hit_c)
  );

  assign period_end_c = CNT_W'(PERIOD_FRAMES - 1) + CNT_W'(jitter);

  // Flash schedule: state only moves on frame_start; enable is sampled there too.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_ALL;
      frame_cnt    <= '0;
      jitter       <= '0;
      rr_idx       <= '0;
      starttrigger <= 1'b0;
      flash_active <= 1'b0;
      flash_count  <= '0;
    end else begin
      starttrigger <= 1'b0;
      if (frame_start) begin
        unique case (state)
          ST_IDLE: begin
            if (enable) begin
              state        <= ST_ON;
              frame_cnt    <= '0;
              rr_idx       <= '0;
              mode_q       <= flash_mode_e'(mode);
              starttrigger <= 1'b1;
              flash_active <= 1'b1;
              flash_count  <= flash_count + COUNT_W'(1);
            end
          end
          ST_ON, ST_OFF: begin
            if (!enable) begin
              state        <= ST_IDLE;
              frame_cnt    <= '0;
              rr_idx       <= '0;
              flash_active <= 1'b0;
            end else if (frame_cnt == period_end_c) begin
              state        <= ST_ON;
              frame_cnt    <= '0;
              jitter       <= (jitter == JIT_W'(JITTER_STEPS - 1)) ? '0 : jitter + JIT_W'(1);
              rr_idx       <= (rr_idx == RR_W'(NUM_FIELDS - 1)) ? '0 : rr_idx + RR_W'(1);
              mode_q       <= flash_mode_e'(mode);
              starttrigger <= 1'b1;
              flash_active <= 1'b1;
              flash_count  <= flash_count + COUNT_W'(1);
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
              if (frame_cnt == CNT_W'(ON_FRAMES - 1)) begin
                state        <= ST_OFF;
                flash_active <= 1'b0;
              end
            end
          end
          default: begin
            state        <= ST_IDLE;
            flash_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel colour selection: lit field beats overlay, overlay beats background.
  always_comb begin
    any_hit_c = |field_hit_c;
    rr_hit_c  = 1'b0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      if (rr_idx == RR_W'(k)) rr_hit_c = field_hit_c[k];
    end
    lit_hit_c = (mode_q == MODE_RR) ? rr_hit_c : any_hit_c;

    pix_c = bg_color;
    if (!pix_valid) begin
      pix_c = '0;
    end else if (flash_active && lit_hit_c) begin
      pix_c = (mode_q == MODE_INV) ? bg_color : fg_color;
    end else if (overlay_en) begin
      pix_c = overlay_pix ? fg_color : bg_color;
    end else if (flash_active && (mode_q == MODE_INV)) begin
      pix_c = fg_color;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data       <= pix_c;
      data_valid <= pix_valid;
    end
  end

endmodule

// File: tb/tb_flash_pattern_gen.sv
// Bench for flash_pattern_gen: directed schedule/pixel tables plus random traffic
// checked against a frame-level reference model.
module tb_flash_pattern_gen;

  localparam int unsigned NF  = 3;
  localparam int unsigned PER = 8;
  localparam int unsigned ONF = 2;
  localparam int unsigned JIT = 2;
  localparam int unsigned CW  = 24;
  localparam logic [CW-1:0] FG = 24'hFF8800;
  localparam logic [CW-1:0] BG = 24'h102030;

  logic clock = 1'b0;
  logic reset, frame_start, pix_valid, enable, overlay_en, overlay_pix;
  logic [11:0] xpos, ypos;
  logic [12*NF-1:0] field_x0, field_x1, field_y0, field_y1;
  logic [1:0] mode;
  logic [CW-1:0] fg_color, bg_color;
  logic starttrigger, flash_active, data_valid;
  logic [CW-1:0] data;
  logic [15:0] flash_count;
  logic trig2, active2, dv2;
  logic [CW-1:0] data2;
  logic [15:0] count2;

  always #5 clock = ~clock;

  flash_pattern_gen #(.NUM_FIELDS(NF), .PERIOD_FRAMES(PER), .ON_FRAMES(ONF),
                      .JITTER_STEPS(JIT), .COLOR_W(CW)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .xpos(xpos), .ypos(ypos), .field_x0(field_x0), .field_x1(field_x1),
    .field_y0(field_y0), .field_y1(field_y1), .enable(enable), .mode(mode),
    .fg_color(fg_color), .bg_color(bg_color), .overlay_en(overlay_en),
    .overlay_pix(overlay_pix), .starttrigger(starttrigger), .flash_active(flash_active),
    .data(data), .data_valid(data_valid), .flash_count(flash_count));

  flash_pattern_gen #(.NUM_FIELDS(NF), .PERIOD_FRAMES(PER), .ON_FRAMES(ONF),
                      .JITTER_STEPS(1), .COLOR_W(CW)) dut_nojit (
    .clock(clock), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .xpos(xpos), .ypos(ypos), .field_x0(field_x0), .field_x1(field_x1),
    .field_y0(field_y0), .field_y1(field_y1), .enable(enable), .mode(mode),
    .fg_color(fg_color), .bg_color(bg_color), .overlay_en(overlay_en),
    .overlay_pix(overlay_pix), .starttrigger(trig2), .flash_active(active2),
    .data(data2), .data_valid(dv2), .flash_count(count2));

  int total = 0;
  int bad   = 0;

  // Reference model: frames since last onset, running flag, onset bookkeeping.
  bit          m_run;
  int          m_since, m_jit, m_rr, m_mode;
  logic [15:0] m_count;

  int cur_frame;
  int trig1_q[$];
  int trig2_q[$];
  bit act_hist[64];
  bit last_trig;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_field(input int k);
    int x0, x1, y0, y1;
    x0 = int'(field_x0[12*k +: 12]); x1 = int'(field_x1[12*k +: 12]);
    y0 = int'(field_y0[12*k +: 12]); y1 = int'(field_y1[12*k +: 12]);
    return (int'(xpos) >= x0) && (int'(xpos) < x1) && (int'(ypos) >= y0) && (int'(ypos) < y1);
  endfunction

  function automatic logic [CW-1:0] model_pix();
    bit on, lit;
    on  = m_run && (m_since < int'(ONF));
    lit = 1'b0;
    for (int k = 0; k < int'(NF); k++)
      if (in_field(k) && (m_mode != 1 || k == m_rr)) lit = 1'b1;
    if (!pix_valid) return '0;
    if (on && lit) return (m_mode == 2) ? bg_color : fg_color;
    if (overlay_en) return overlay_pix ? fg_color : bg_color;
    return (on && m_mode == 2) ? fg_color : bg_color;
  endfunction

  // One clock: predict, advance, sample 1 time unit after the edge, compare.
  task automatic step();
    logic [CW-1:0] e_data;
    logic e_dv, e_trig;
    e_data = reset ? '0 : model_pix();
    e_dv   = reset ? 1'b0 : pix_valid;
    e_trig = 1'b0;
    if (reset) begin
      m_run = 0; m_since = 0; m_jit = 0; m_rr = 0; m_mode = 0; m_count = '0;
    end else if (frame_start) begin
      if (!enable) begin
        m_run = 0; m_rr = 0;
      end else if (!m_run) begin
        m_run = 1; m_since = 0; m_rr = 0; e_trig = 1'b1;
        m_count = m_count + 16'd1; m_mode = int'(mode);
      end else begin
        m_since++;
        if (m_since == int'(PER) + m_jit) begin
          m_since = 0; m_jit = (m_jit + 1) % int'(JIT); m_rr = (m_rr + 1) % int'(NF);
          e_trig = 1'b1; m_count = m_count + 16'd1; m_mode = int'(mode);
        end
      end
    end
    @(posedge clock);
    #1;
    check("starttrigger", starttrigger, e_trig);
    check("flash_active", flash_active, m_run && (m_since < int'(ONF)));
    check("data", data, e_data);
    check("data_valid", data_valid, e_dv);
    check("flash_count", flash_count, m_count);
    last_trig = starttrigger;
    if (starttrigger) trig1_q.push_back(cur_frame);
    if (trig2) trig2_q.push_back(cur_frame);
  endtask

  task automatic frame(input int gap);
    cur_frame++;
    frame_start = 1'b1;
    step();
    if (cur_frame >= 0 && cur_frame < 64) act_hist[cur_frame] = flash_active;
    frame_start = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0;
    step(); step();
    reset = 1'b0;
    cur_frame = -1;
    trig1_q.delete(); trig2_q.delete();
  endtask

  task automatic set_field(input int k, input int x0, input int x1, input int y0, input int y1);
    field_x0[12*k +: 12] = 12'(x0); field_x1[12*k +: 12] = 12'(x1);
    field_y0[12*k +: 12] = 12'(y0); field_y1[12*k +: 12] = 12'(y1);
  endtask

  typedef struct {
    logic [11:0] x, y;
    logic pv, oe, op;
    int   exp;  // 0 = zero, 1 = fg, 2 = bg
  } pix_vec_t;
  pix_vec_t tbl[10];

  initial begin
    int onset_n, guard;
    logic [CW-1:0] ev;
    int exp1[5] = '{0, 8, 17, 25, 34};
    int exp2[5] = '{0, 8, 16, 24, 32};

    tbl[0] = '{12'd150, 12'd55, 1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{12'd200, 12'd55, 1'b1, 1'b0, 1'b0, 2};
    tbl[2] = '{12'd99,  12'd55, 1'b1, 1'b0, 1'b0, 2};
    tbl[3] = '{12'd100, 12'd50, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{12'd199, 12'd59, 1'b1, 1'b0, 1'b0, 1};
    tbl[5] = '{12'd150, 12'd60, 1'b1, 1'b0, 1'b0, 2};
    tbl[6] = '{12'd150, 12'd55, 1'b0, 1'b0, 1'b0, 0};
    tbl[7] = '{12'd300, 12'd300, 1'b1, 1'b1, 1'b1, 1};
    tbl[8] = '{12'd300, 12'd300, 1'b1, 1'b1, 1'b0, 2};
    tbl[9] = '{12'd150, 12'd55, 1'b1, 1'b1, 1'b0, 1};

    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; enable = 1'b0;
    overlay_en = 1'b0; overlay_pix = 1'b0; mode = 2'd0; xpos = '0; ypos = '0;
    fg_color = FG; bg_color = BG;
    field_x0 = '0; field_x1 = '0; field_y0 = '0; field_y1 = '0;
    cur_frame = -1;

    // Schedule: 40 frames, jittered and unjittered instances.
    do_reset();
    check("reset_count", flash_count, 16'd0);
    check("reset_active", flash_active, 1'b0);
    enable = 1'b1;
    repeat (40) frame(2);
    check("sched_ntrig", trig1_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < trig1_q.size()) check("sched_trig_frame", trig1_q[i], exp1[i]);
    check("sched_count", flash_count, 16'd5);
    check("act_f1", act_hist[1], 1'b1);
    check("act_f2", act_hist[2], 1'b0);
    check("act_f9", act_hist[9], 1'b1);
    check("act_f16", act_hist[16], 1'b0);
    check("act_f18", act_hist[18], 1'b1);
    check("nojit_ntrig", trig2_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < trig2_q.size()) check("nojit_trig_frame", trig2_q[i], exp2[i]);
    check("nojit_count", count2, 16'd5);

    // Pixel table, mode 0, while ON.
    do_reset();
    set_field(0, 100, 200, 50, 60); set_field(1, 0, 0, 0, 0); set_field(2, 5, 5, 5, 5);
    enable = 1'b1; mode = 2'd0;
    frame(0);
    for (int i = 0; i < 10; i++) begin
      xpos = tbl[i].x; ypos = tbl[i].y; pix_valid = tbl[i].pv;
      overlay_en = tbl[i].oe; overlay_pix = tbl[i].op;
      step();
      ev = (tbl[i].exp == 1) ? FG : (tbl[i].exp == 2) ? BG : '0;
      check("tbl_data", data, ev);
      check("tbl_valid", data_valid, tbl[i].pv);
    end
    overlay_en = 1'b0;

    // Round-robin across four onsets.
    do_reset();
    set_field(0, 0, 10, 0, 10); set_field(1, 20, 30, 0, 10); set_field(2, 40, 50, 0, 10);
    mode = 2'd1; enable = 1'b1; onset_n = 0; guard = 0;
    while (onset_n < 4 && guard < 60) begin
      guard++;
      frame(0);
      if (last_trig) begin
        onset_n++;
        for (int k = 0; k < 3; k++) begin
          xpos = 12'(5 + 20 * k); ypos = 12'd5; pix_valid = 1'b1;
          step();
          check("rr_field", data, (k == (onset_n - 1) % 3) ? FG : BG);
        end
      end
    end
    check("rr_onsets", onset_n, 4);

    // Inverted mode with overlay.
    do_reset();
    set_field(0, 100, 200, 50, 60); set_field(1, 0, 0, 0, 0); set_field(2, 0, 0, 0, 0);
    mode = 2'd2; enable = 1'b1;
    frame(0);
    xpos = 12'd150; ypos = 12'd55; pix_valid = 1'b1; step();
    check("inv_in_field", data, BG);
    xpos = 12'd300; step();
    check("inv_off_field", data, FG);
    overlay_en = 1'b1; overlay_pix = 1'b0; step();
    check("inv_overlay0", data, BG);
    overlay_pix = 1'b1; step();
    check("inv_overlay1", data, FG);
    overlay_en = 1'b0; mode = 2'd0;

    // Abort via enable and restart.
    do_reset();
    enable = 1'b1;
    repeat (4) frame(1);
    enable = 1'b0;
    frame(1);
    check("abort_active", flash_active, 1'b0);
    repeat (5) frame(1);
    enable = 1'b1;
    frame(1);
    check("abort_ntrig", trig1_q.size(), 2);
    if (trig1_q.size() >= 2) check("restart_frame", trig1_q[1], 10);

    // Reset during ON.
    do_reset();
    set_field(0, 100, 200, 50, 60);
    enable = 1'b1;
    frame(0);
    xpos = 12'd150; ypos = 12'd55; pix_valid = 1'b1; step();
    check("pre_rst_data", data, FG);
    reset = 1'b1; step();
    check("rst_data", data, 24'd0);
    check("rst_active", flash_active, 1'b0);
    check("rst_count", flash_count, 16'd0);
    reset = 1'b0; step(); step();
    check("rst_no_trig", starttrigger, 1'b0);
    frame(0);
    check("rst_retrig", last_trig, 1'b1);
    check("rst_count1", flash_count, 16'd1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      frame_start = ($urandom_range(0, 5) == 0);
      enable      = ($urandom_range(0, 15) != 0);
      reset       = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        for (int k = 0; k < int'(NF); k++)
          set_field(k, $urandom_range(0, 40), $urandom_range(0, 63),
                    $urandom_range(0, 40), $urandom_range(0, 63));
      end
      if ($urandom_range(0, 99) == 0) begin
        fg_color = CW'($urandom); bg_color = CW'($urandom);
      end
      pix_valid   = ($urandom_range(0, 3) != 0);
      xpos        = 12'($urandom_range(0, 63));
      ypos        = 12'($urandom_range(0, 63));
      overlay_en  = ($urandom_range(0, 3) == 0);
      overlay_pix = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
